// File: rtl/fir_filter_mc_pkg.sv
// Shared types and helpers for the multi-channel time-multiplexed FIR filter.
// Holds the FSM encoding, width helpers and the output round/saturate function.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_res_t;

  function automatic int unsigned calc_cw(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int unsigned calc_wa(input int unsigned w_x, input int unsigned w_b,
                                          input int unsigned n_taps);
    return w_x + w_b + $clog2(n_taps);
  endfunction

  // Round half up by 'shift' bits, then clamp into a signed w_y-bit range.
  function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                         input int unsigned shift,
                                         input int unsigned w_y);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi      = (64'sd1 <<< (w_y - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w_y - 1));
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_filter_mc_if.sv
// Sample-in / filtered-sample-out valid/ready streams of fir_filter_mc.
interface fir_filter_mc_if
  import fir_mc_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned W_X  = 8,
  parameter int unsigned W_Y  = 16
);
  localparam int unsigned CW = calc_cw(N_CH);

  logic                  s_valid;
  logic                  s_ready;
  logic signed [W_X-1:0] s_data;
  logic [CW-1:0]         s_ch;
  logic                  m_valid;
  logic                  m_ready;
  logic signed [W_Y-1:0] m_data;
  logic [CW-1:0]         m_ch;
  logic                  m_sat;

  modport master (
    output s_valid, s_data, s_ch, m_ready,
    input  s_ready, m_valid, m_data, m_ch, m_sat
  );

  modport slave (
    input  s_valid, s_data, s_ch, m_ready,
    output s_ready, m_valid, m_data, m_ch, m_sat
  );
endinterface

// File: rtl/fir_filter_mc_mac.sv
// Registered signed multiply-accumulate used serially across taps.
module fir_mac #(
  parameter int unsigned W_X = 8,
  parameter int unsigned W_B = 8,
  parameter int unsigned W_A = 19
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic signed [W_X-1:0] i_x,
  input  logic signed [W_B-1:0] i_b,
  output logic signed [W_A-1:0] o_acc
);
  logic signed [W_X+W_B-1:0] w_prod;
  logic signed [W_A-1:0]     r_acc;

  assign w_prod = i_x * i_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + W_A'(w_prod);
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR filter: per-channel sample history, run-time coefficients,
// one serial MAC walking the taps, rounded/saturated registered output.
module fir_filter_mc
  import fir_mc_pkg::*;
#(
  parameter int unsigned              N_TAPS = 6,
  parameter int unsigned              N_CH   = 2,
  parameter int unsigned              W_X    = 8,
  parameter int unsigned              W_B    = 8,
  parameter int unsigned              W_Y    = 16,
  parameter int unsigned              SHIFT  = 0,
  parameter logic [N_TAPS*W_B-1:0]    B_INIT = 48'h06_05_04_03_02_01
) (
  input  logic                        clk,
  input  logic                        rstn,
  fir_filter_mc_if.slave              bus,
  input  logic                        coef_we,
  input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [W_B-1:0]       coef_data,
  output logic                        busy
);
  localparam int unsigned CW  = calc_cw(N_CH);
  localparam int unsigned W_A = calc_wa(W_X, W_B, N_TAPS);
  localparam int unsigned AW  = $clog2(N_TAPS);
  localparam int unsigned IW  = $clog2(N_TAPS + 1);

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_ch;
  logic signed [W_X-1:0] r_z [N_CH][N_TAPS];
  logic signed [W_B-1:0] r_b [N_TAPS];
  logic                  r_m_valid;
  logic signed [W_Y-1:0] r_m_data;
  logic [CW-1:0]         r_m_ch;
  logic                  r_m_sat;

  logic                  w_ch_ok;
  logic                  w_accept;
  logic                  w_mac_en;
  logic signed [W_X-1:0] w_x;
  logic signed [W_B-1:0] w_b;
  logic signed [W_A-1:0] w_acc;
  sat_res_t              w_res;

  // Channel tags beyond N_CH are swallowed without touching any history.
  always_comb begin
    w_ch_ok = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (bus.s_ch == CW'(c)) w_ch_ok = 1'b1;
    end
  end

  assign w_accept = (r_state == IDLE) && bus.s_valid && w_ch_ok;
  assign w_mac_en = (r_state == MAC) && (r_idx != IW'(N_TAPS));

  // Operand select for the current tap of the channel being filtered.
  always_comb begin
    w_x = '0;
    w_b = '0;
    for (int k = 0; k < int'(N_TAPS); k++) begin
      if (r_idx == IW'(k)) begin
        w_b = r_b[k];
        for (int c = 0; c < int'(N_CH); c++) begin
          if (r_ch == CW'(c)) w_x = r_z[c][k];
        end
      end
    end
  end

  fir_mac #(
    .W_X (W_X),
    .W_B (W_B),
    .W_A (W_A)
  ) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (w_accept),
    .i_en  (w_mac_en),
    .i_x   (w_x),
    .i_b   (w_b),
    .o_acc (w_acc)
  );

  assign w_res = sat_round(64'(w_acc), SHIFT, W_Y);

  // Control FSM plus history, coefficient and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ch      <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ch    <= '0;
      r_m_sat   <= 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int k = 0; k < int'(N_TAPS); k++) r_z[c][k] <= '0;
      end
      for (int k = 0; k < int'(N_TAPS); k++) r_b[k] <= B_INIT[k*W_B +: W_B];
    end else begin
      case (r_state)
        IDLE: begin
          if (coef_we) begin
            for (int k = 0; k < int'(N_TAPS); k++) begin
              if (coef_addr == AW'(k)) r_b[k] <= coef_data;
            end
          end
          if (w_accept) begin
            for (int c = 0; c < int'(N_CH); c++) begin
              if (bus.s_ch == CW'(c)) begin
                for (int k = int'(N_TAPS) - 1; k > 0; k--) r_z[c][k] <= r_z[c][k-1];
                r_z[c][0] <= bus.s_data;
              end
            end
            r_ch    <= bus.s_ch;
            r_idx   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (r_idx == IW'(N_TAPS)) begin
            r_m_valid <= 1'b1;
            r_m_data  <= W_Y'(w_res.val);
            r_m_sat   <= w_res.sat;
            r_m_ch    <= r_ch;
            r_state   <= OUT;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = rstn && (r_state == IDLE);
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_ch    = r_m_ch;
  assign bus.m_sat   = r_m_sat;
  assign busy        = (r_state != IDLE);
endmodule
